// File: rtl/dram_arb_pkg.sv
// ============================================================================
// Module : dram_arb_pkg
// Brief  : Shared types and constants for the two-port DRAM arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dram_arb_pkg;

  localparam int DATA_W = 32;

  // State records which port was granted in the previous cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dram_arb_pick.sv
// ============================================================================
// Module : dram_arb_pick
// Brief  : Grant selection and ownership FSM for the DRAM arbiter.
//          DRAM_ARB_FAIRNESS_EN enables the MAX_BURST forced hand-over;
//          without it port 0 has strict priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_arb_pick
  import dram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_gnt,
  output logic m1_gnt
);

  arb_state_e state_q, state_d;

`ifdef DRAM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             burst_full;

  assign burst_full = (burst_cnt_q == CNT_W'(MAX_BURST));
`else
  logic unused_max_burst;
  assign unused_max_burst = (MAX_BURST != 0);
`endif

  // Grants are masked by rst_n so they drop the moment reset asserts.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      case (state_q)
        OWN0: begin
`ifdef DRAM_ARB_FAIRNESS_EN
          if (m0_req && !(burst_full && m1_req)) m0_gnt = 1'b1;
          else if (m1_req)                       m1_gnt = 1'b1;
`else
          if (m0_req)      m0_gnt = 1'b1;
          else if (m1_req) m1_gnt = 1'b1;
`endif
        end
        OWN1: begin
`ifdef DRAM_ARB_FAIRNESS_EN
          if (m1_req && !(burst_full && m0_req)) m1_gnt = 1'b1;
          else if (m0_req)                       m0_gnt = 1'b1;
`else
          if (m0_req)      m0_gnt = 1'b1;
          else if (m1_req) m1_gnt = 1'b1;
`endif
        end
        default: begin
          if (m0_req)      m0_gnt = 1'b1;
          else if (m1_req) m1_gnt = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d = IDLE;
    if (m0_gnt)      state_d = OWN0;
    else if (m1_gnt) state_d = OWN1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef DRAM_ARB_FAIRNESS_EN
  always_comb begin
    burst_cnt_d = '0;
    if ((m0_gnt && state_q == OWN0) || (m1_gnt && state_q == OWN1))
      burst_cnt_d = burst_full ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
    else if (m0_gnt || m1_gnt)
      burst_cnt_d = CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_cnt_q <= '0;
    else        burst_cnt_q <= burst_cnt_d;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/dram_arbiter.sv
// ============================================================================
// Module : dram_arbiter
// Brief  : Two-port (CPU / loader) arbiter onto a single-cycle DRAM.
//          Optional macro DRAM_ARB_FAIRNESS_EN enables burst-limited fairness.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_we,
  input  logic [DATA_W-1:0] dram_rdata
);

  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q,  m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q,  m1_rdata_d;

  // Only word-address bits reach the DRAM; the rest of each byte address is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr, m1_addr};

  dram_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .m0_req (m0_req),
    .m1_req (m1_req),
    .m0_gnt (m0_gnt),
    .m1_gnt (m1_gnt)
  );

  always_comb begin
    dram_addr  = m0_addr[ADDR_W+1:2];
    dram_wdata = m0_wdata;
    dram_we    = m0_gnt & m0_we;
    if (m1_gnt) begin
      dram_addr  = m1_addr[ADDR_W+1:2];
      dram_wdata = m1_wdata;
      dram_we    = m1_we;
    end
  end

  always_comb begin
    m0_rvalid_d = m0_gnt & ~m0_we;
    m1_rvalid_d = m1_gnt & ~m1_we;
    m0_rdata_d  = m0_rvalid_d ? dram_rdata : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? dram_rdata : m1_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_arbiter.sv
// ============================================================================
// Module : tb_dram_arbiter
// Brief  : Directed plus randomized self-checking bench for dram_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dram_arbiter;

  localparam int TB_ADDR_W    = 14;
  localparam int TB_MAX_BURST = 4;
  localparam int MEM_WORDS    = 1 << TB_ADDR_W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 m0_req, m0_we, m1_req, m1_we;
  logic [31:0]          m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic                 m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]          m0_rdata, m1_rdata;
  logic [TB_ADDR_W-1:0] dram_addr;
  logic [31:0]          dram_wdata, dram_rdata;
  logic                 dram_we;

  logic [31:0] mem    [0:MEM_WORDS-1];
  logic [31:0] shadow [0:MEM_WORDS-1];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          own = -1;
  int          run = 0;
  bit          erv0 = 1'b0, erv1 = 1'b0;
  logic [31:0] erd0 = '0, erd1 = '0;
  bit          mg0 = 1'b0, mg1 = 1'b0;

  always #5 clk = ~clk;

  dram_arbiter #(
    .ADDR_W    (TB_ADDR_W),
    .MAX_BURST (TB_MAX_BURST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_we    (dram_we),
    .dram_rdata (dram_rdata)
  );

  // The DRAM itself: combinational read, write on the clock edge.
  assign dram_rdata = mem[dram_addr];
  always @(posedge clk) if (dram_we) mem[dram_addr] <= dram_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int waddr(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << TB_ADDR_W) - 32'd1));
  endfunction

  // Which port the rules say wins this cycle (-1 for none).
  function automatic int model_pick(input bit r0, input bit r1);
`ifdef DRAM_ARB_FAIRNESS_EN
    bit rx, ry;
    if (own < 0) return r0 ? 0 : (r1 ? 1 : -1);
    rx = (own == 1) ? r1 : r0;
    ry = (own == 1) ? r0 : r1;
    if (rx && !(run >= TB_MAX_BURST && ry)) return own;
    if (ry) return 1 - own;
    return -1;
`else
    return r0 ? 0 : (r1 ? 1 : -1);
`endif
  endfunction

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 31)) << 2);
  endfunction

  // Compare process: checks every cycle against the model, then advances it.
  always @(negedge clk) begin
    int          g;
    logic [31:0] a, wd;
    logic        we;
    if (!rst_n) begin
      chk("rst_gnt",    {m1_gnt, m0_gnt}, 0);
      chk("rst_we",     dram_we, 0);
      chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
      chk("rst_rdata0", m0_rdata, 0);
      chk("rst_rdata1", m1_rdata, 0);
      own = -1; run = 0;
      erv0 = 0; erv1 = 0; erd0 = '0; erd1 = '0;
      mg0 = 0; mg1 = 0;
    end else begin
      chk("rvalid0", m0_rvalid, erv0);
      chk("rdata0",  m0_rdata,  erd0);
      chk("rvalid1", m1_rvalid, erv1);
      chk("rdata1",  m1_rdata,  erd1);
      g = model_pick(m0_req, m1_req);
      chk("gnt", {m1_gnt, m0_gnt}, (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00);
      erv0 = 0; erv1 = 0;
      mg0 = (g == 0); mg1 = (g == 1);
      if (g < 0) begin
        chk("idle_we", dram_we, 0);
        own = -1; run = 0;
      end else begin
        a  = (g == 1) ? m1_addr  : m0_addr;
        we = (g == 1) ? m1_we    : m0_we;
        wd = (g == 1) ? m1_wdata : m0_wdata;
        chk("dram_addr", dram_addr, waddr(a));
        chk("dram_we",   dram_we, we);
        if (we) begin
          chk("dram_wdata", dram_wdata, wd);
          shadow[waddr(a)] = wd;
        end else if (g == 0) begin
          erv0 = 1; erd0 = shadow[waddr(a)];
        end else begin
          erv1 = 1; erd1 = shadow[waddr(a)];
        end
        run = (g == own) ? run + 1 : 1;
        own = g;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] exp_seq;
    int          rate;

    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]    <= '0;
      shadow[i] = '0;
    end
    mem[4]    <= 32'hDEAD_BEEF;
    shadow[4] = 32'hDEAD_BEEF;

    // Reset held with both ports requesting
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (2) cyc();
    #2;
    chk("r033_gnt",    {m1_gnt, m0_gnt}, 2'b00);
    chk("r033_we",     dram_we, 0);
    chk("r033_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    cyc(); m0_req = 1'b0; m1_req = 1'b0; rst_n = 1'b1;
    cyc();

    // Read latency
    cyc(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    #2; chk("r034_gnt", m0_gnt, 1); chk("r034_addr", dram_addr, 4);
    cyc(); m0_req = 1'b0;
    #2; chk("r034_rvalid", m0_rvalid, 1); chk("r034_rdata", m0_rdata, 32'hDEAD_BEEF);
    cyc();
    #2; chk("r034_rvalid_once", m0_rvalid, 0); chk("r034_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

    // Write isolation
    cyc(); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0020; m1_wdata = 32'h1234_5678;
    #2;
    chk("r035_gnt",   {m1_gnt, m0_gnt}, 2'b10);
    chk("r035_we",    dram_we, 1);
    chk("r035_addr",  dram_addr, 8);
    chk("r035_wdata", dram_wdata, 32'h1234_5678);
    cyc(); m1_req = 1'b0; m1_we = 1'b0;
    #2; chk("r035_no_rvalid", m1_rvalid, 0); chk("r035_gnt_off", m1_gnt, 0); chk("r035_we_off", dram_we, 0);
    cyc();

    // Both ports requesting continuously from IDLE
`ifdef DRAM_ARB_FAIRNESS_EN
    exp_seq = 12'h0F0;
`else
    exp_seq = 12'h000;
`endif
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 0) begin
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
      end
      #2;
      chk($sformatf("burst_seq[%0d]", i), {m1_gnt, m0_gnt}, exp_seq[i] ? 2'b10 : 2'b01);
    end
    cyc(); m0_req = 1'b0;
    #2; chk("m0_drop_m1_gnt", {m1_gnt, m0_gnt}, 2'b10);
    cyc(); m1_req = 1'b0;
    cyc();

    // Reset in the cycle after an m1 read grant
    cyc(); m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0040;
    #2; chk("r038_m1_gnt", m1_gnt, 1);
    cyc(); m1_req = 1'b0; rst_n = 1'b0;
    #2; chk("r038_no_rvalid", m1_rvalid, 0); chk("r038_rdata_clr", m1_rdata, 0);
    cyc(); rst_n = 1'b1; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    #2; chk("r038_resume_gnt", {m1_gnt, m0_gnt}, 2'b01);
    cyc(); m0_req = 1'b0;
    #2; chk("r038_resume_rdata", m0_rdata, 32'hDEAD_BEEF);
    cyc();

    // Randomized traffic; requesters hold until granted
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rate = ((c / 500) % 3 == 0) ? 35 : ((c / 500) % 3 == 1) ? 95 : 65;
      if (c == 1500) begin
        rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      end else if (c == 1503) begin
        rst_n = 1'b1;
      end
      if (rst_n) begin
        if (!m0_req || mg0) begin
          if ($urandom_range(0, 99) < rate) begin
            m0_req = 1'b1; m0_we = 1'($urandom_range(0, 1));
            m0_addr = rand_addr(); m0_wdata = $urandom;
          end else m0_req = 1'b0;
        end
        if (!m1_req || mg1) begin
          if ($urandom_range(0, 99) < rate) begin
            m1_req = 1'b1; m1_we = 1'($urandom_range(0, 1));
            m1_addr = rand_addr(); m1_wdata = $urandom;
          end else m1_req = 1'b0;
        end
      end
    end
    cyc(); m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
